// File: rtl/sn_stream_gen.sv
// sn_stream_gen: binary-to-stochastic encoder that turns DIM signed bipolar values into SN bit streams
// Ports:
//   i_clk_sng    clock, rising edge
//   i_rst_sng    asynchronous active-high reset
//   i_start_sng  start pulse, sampled only in IDLE
//   i_stop_sng   early abort, sampled only in GEN
//   i_len_sng    stream length in bits, 0 selects the full 2^NUM_BIT period
//   i_x_sng      DIM signed two's-complement lane values
//   o_isgen      SN bits valid
//   o_sn_bit     one SN bit per lane, 0 outside GEN
//   o_done_sng   one-cycle pulse after the last bit
//   o_busy_sng   high while not IDLE
module sn_stream_gen #(
    parameter int NUM_BIT = 4,
    parameter int DIM     = 4
) (
    input  logic                          i_clk_sng,
    input  logic                          i_rst_sng,
    input  logic                          i_start_sng,
    input  logic                          i_stop_sng,
    input  logic [NUM_BIT-1:0]            i_len_sng,
    input  logic [DIM-1:0][NUM_BIT-1:0]   i_x_sng,
    output logic                          o_isgen,
    output logic [DIM-1:0]                o_sn_bit,
    output logic                          o_done_sng,
    output logic                          o_busy_sng
);
    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
    // Length is held one bit wider so the full period 2^NUM_BIT is representable.
    localparam logic [NUM_BIT:0] LEN_FULL = {1'b1, {NUM_BIT{1'b0}}};
    state_t                        state_q, state_d;
    logic [NUM_BIT:0]              cnt_q, cnt_d;
    logic [NUM_BIT:0]              len_q, len_d;
    logic [DIM-1:0][NUM_BIT-1:0]   x_q, x_d;
    logic [NUM_BIT-1:0]            rev;
    always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
        if (i_rst_sng) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            x_q     <= x_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        x_d     = x_q;
        case (state_q)
            IDLE: if (i_start_sng) begin
                state_d = GEN;
                cnt_d   = '0;
                x_d     = i_x_sng;
                len_d   = (i_len_sng == '0) ? LEN_FULL : {1'b0, i_len_sng};
            end
            GEN: if (i_stop_sng || (cnt_q + 1'b1) == len_q) state_d = DONE;
                 else cnt_d = cnt_q + 1'b1;
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    assign o_isgen    = (state_q == GEN);
    assign o_done_sng = (state_q == DONE);
    assign o_busy_sng = (state_q != IDLE);
    // Bit-reversed counter spreads the ones of each stream evenly over the period.
    for (genvar b = 0; b < NUM_BIT; b++) begin : g_rev
        assign rev[b] = cnt_q[NUM_BIT-1-b];
    end
    // Adding 2^(N-1) to a two's-complement value is the same as flipping its sign bit.
    for (genvar l = 0; l < DIM; l++) begin : g_lane
        logic [NUM_BIT-1:0] off;
        assign off         = {~x_q[l][NUM_BIT-1], x_q[l][NUM_BIT-2:0]};
        assign o_sn_bit[l] = o_isgen & (rev < off);
    end
endmodule

// File: tb/tb_sn_stream_gen.sv
// tb_sn_stream_gen: self-checking bench for sn_stream_gen against a behavioural stream model
module tb_sn_stream_gen;
    logic            clk, rst, start, stop;
    logic [3:0]      len_i;
    logic [3:0][3:0] x_i;
    logic            isgen, done, busy;
    logic [3:0]      sn;
    int              checks, errors;
    int              ones [4];

    sn_stream_gen #(.NUM_BIT(4), .DIM(4)) dut (
        .i_clk_sng(clk), .i_rst_sng(rst), .i_start_sng(start), .i_stop_sng(stop),
        .i_len_sng(len_i), .i_x_sng(x_i),
        .o_isgen(isgen), .o_sn_bit(sn), .o_done_sng(done), .o_busy_sng(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bitrev(input int c);
        int r = 0;
        for (int b = 0; b < 4; b++) begin
            r = r * 2 + c % 2;
            c = c / 2;
        end
        return r;
    endfunction

    // Expected SN bits of the j-th stream cycle: threshold x+8 against bit-reversed j.
    function automatic logic [3:0] ref_bits(input logic [3:0][3:0] xs, input int j);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = bitrev(j) < ($signed(xs[i]) + 8);
        return v;
    endfunction

    task automatic run(input logic [3:0][3:0] xs, input int len, input int stop_at,
                       input bit noise, input bit both);
        int l, n;
        logic [3:0] e;
        l = (len == 0) ? 16 : len;
        n = (stop_at >= 0 && stop_at + 1 < l) ? stop_at + 1 : l;
        for (int i = 0; i < 4; i++) ones[i] = 0;
        x_i = xs; len_i = len[3:0]; start = 1; stop = both;
        step();
        start = 0; stop = 0;
        for (int j = 0; j < n; j++) begin
            e = ref_bits(xs, j);
            check("isgen", isgen, 1);
            check("sn_bit", sn, e);
            check("busy_gen", busy, 1);
            check("done_gen", done, 0);
            for (int i = 0; i < 4; i++) ones[i] += sn[i];
            stop = (j == stop_at);
            if (noise) begin
                start = 1'($urandom);
                x_i   = 16'($urandom);
                len_i = 4'($urandom);
            end
            step();
        end
        stop = 0;
        check("done_pulse", done, 1);
        check("isgen_done", isgen, 0);
        check("sn_done", sn, 0);
        check("busy_done", busy, 1);
        if (noise) start = 1;
        step();
        start = 0;
        check("done_after", done, 0);
        check("busy_idle", busy, 0);
        check("isgen_idle", isgen, 0);
        if (n == 16)
            for (int i = 0; i < 4; i++) check("ones_full", ones[i], $signed(xs[i]) + 8);
    endtask

    initial begin
        logic [3:0][3:0] xs;
        checks = 0; errors = 0;
        rst = 1; start = 0; stop = 0; len_i = 0; x_i = 0;
        #2;
        check("rst_isgen", isgen, 0);
        check("rst_sn", sn, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        step(); step();
        #2 rst = 0;
        step();
        check("idle_busy", busy, 0);

        xs = '0;
        run(xs, 8, -1, 0, 0);
        check("t1_ones", ones[0], 4);

        xs = {4'h7, 4'h0, 4'hF, 4'h8};
        run(xs, 0, -1, 0, 0);
        check("t2_ones0", ones[0], 0);
        check("t2_ones1", ones[1], 7);
        check("t2_ones2", ones[2], 8);
        check("t2_ones3", ones[3], 15);

        xs = '0;
        run(xs, 0, 4, 0, 0);
        check("t3_ones", ones[0], 3);

        xs = {4'h3, 4'hC, 4'h1, 4'h6};
        run(xs, 11, -1, 1, 0);
        run(xs, 5, -1, 0, 0);

        xs = {4'h2, 4'hA, 4'h5, 4'hE};
        x_i = xs; len_i = 0; start = 1;
        step();
        start = 0;
        for (int j = 0; j < 6; j++) begin
            check("t5_sn", sn, ref_bits(xs, j));
            if (j < 5) step();
        end
        #2 rst = 1;
        #1;
        check("t5_isgen", isgen, 0);
        check("t5_sn0", sn, 0);
        check("t5_done", done, 0);
        check("t5_busy", busy, 0);
        #2 rst = 0;
        run(xs, 0, -1, 0, 0);

        xs = {4'hF, 4'hF, 4'hF, 4'hF};
        run(xs, 1, -1, 0, 0);
        check("t6_ones", ones[0], 1);
        run(xs, 1, 0, 0, 0);
        run(xs, 3, 2, 0, 1);

        for (int k = 0; k < 10; k++) begin
            int sa;
            xs = 16'($urandom);
            sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
            run(xs, int'($urandom_range(0, 15)), sa, 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
